// File: rtl/cs_round_robin_seq.sv
// Round-robin sequencer that time-shares a 3-to-8 active-low decoder among
// eight requesters, with a one-cycle break-before-make gap between selects.
module cs_round_robin_seq #(
  parameter int DWELL_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [7:0]         REQ,
  input  logic [DWELL_W-1:0] DWELL,
  output logic               G1,
  output logic               G2A,
  output logic               G2B,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic [7:0]         ACK,
  output logic               BUSY,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  logic [1:0]         state;
  logic [DWELL_W-1:0] cnt;
  logic [2:0]         ptr;
  logic [2:0]         idx;
  logic [2:0]         win;

  // Scanning downward lets the lowest offset from ptr win the last assignment.
  function automatic logic [2:0] pick(input logic [2:0] p, input logic [7:0] r);
    logic [2:0] k;
    logic [2:0] w;
    w = p;
    for (int i = 7; i >= 0; i--) begin
      k = p + 3'(i);
      if (r[k]) w = k;
    end
    return w;
  endfunction

  assign win       = pick(ptr, REQ);
  assign {C, B, A} = idx;
  assign state_dbg = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      ptr   <= 3'd0;
      idx   <= 3'd0;
      G1    <= 1'b0;
      G2A   <= 1'b1;
      G2B   <= 1'b1;
      ACK   <= 8'h00;
      BUSY  <= 1'b0;
    end else begin
      ACK <= 8'h00;
      case (state)
        S_IDLE, S_GAP: begin
          if (|REQ) begin
            state <= S_SELECT;
            idx   <= win;
            cnt   <= DWELL;
            ptr   <= win + 3'd1;
            G1    <= 1'b1;
            G2A   <= 1'b0;
            G2B   <= 1'b0;
            BUSY  <= 1'b1;
          end else begin
            state <= S_IDLE;
            G1    <= 1'b0;
            G2A   <= 1'b1;
            G2B   <= 1'b1;
            BUSY  <= 1'b0;
          end
        end
        S_SELECT: begin
          // A dropped request ends the select early and forfeits the ACK.
          if (!REQ[idx] || cnt == '0) begin
            state <= S_GAP;
            G1    <= 1'b0;
            G2A   <= 1'b1;
            G2B   <= 1'b1;
            BUSY  <= 1'b1;
            if (REQ[idx]) ACK <= 8'h01 << idx;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          G1    <= 1'b0;
          G2A   <= 1'b1;
          G2B   <= 1'b1;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cs_round_robin_seq.sv
// Directed bench: the driver pushes the hand-computed output vector expected
// after each edge; the monitor pops and compares one vector per cycle.
module tb_cs_round_robin_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] REQ = 8'h00;
  logic [3:0] DWELL = 4'h0;
  logic       G1, G2A, G2B, A, B, C, BUSY;
  logic [7:0] ACK;
  logic [1:0] state_dbg;

  logic [16:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        done = 1'b0;

  cs_round_robin_seq #(.DWELL_W(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DWELL(DWELL),
    .G1(G1), .G2A(G2A), .G2B(G2B), .A(A), .B(B), .C(C),
    .ACK(ACK), .BUSY(BUSY), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  // Vector layout: {state, G1, G2A, G2B, C, B, A, ACK, BUSY}
  function automatic logic [16:0] v_idle(input logic [2:0] i);
    return {2'd0, 1'b0, 1'b1, 1'b1, i, 8'h00, 1'b0};
  endfunction
  function automatic logic [16:0] v_sel(input logic [2:0] i);
    return {2'd1, 1'b1, 1'b0, 1'b0, i, 8'h00, 1'b1};
  endfunction
  function automatic logic [16:0] v_gap(input logic [2:0] i, input logic [7:0] ack);
    return {2'd2, 1'b0, 1'b1, 1'b1, i, ack, 1'b1};
  endfunction

  task automatic step(input logic rst, input logic [7:0] req, input logic [3:0] dw,
                      input logic [16:0] e, input string nm);
    @(negedge CLK);
    RST   = rst;
    REQ   = req;
    DWELL = dw;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    // reset state
    step(1'b1, 8'h00, 4'h0, v_idle(3'd0), "reset0");
    step(1'b1, 8'h00, 4'h0, v_idle(3'd0), "reset1");

    // single request, DWELL=2; other REQ bits and DWELL wiggle mid-select
    step(1'b0, 8'h20, 4'h2, v_sel(3'd5), "single_sel0");
    step(1'b0, 8'h22, 4'h9, v_sel(3'd5), "single_sel1");
    step(1'b0, 8'h2a, 4'h9, v_sel(3'd5), "single_sel2");
    step(1'b0, 8'h20, 4'h9, v_gap(3'd5, 8'h20), "single_gap");
    step(1'b0, 8'h00, 4'h0, v_idle(3'd5), "single_idle");

    // wrap/priority from ptr=6 with REQ=61
    step(1'b0, 8'h61, 4'h0, v_sel(3'd6), "wrap_sel6");
    step(1'b0, 8'h61, 4'h0, v_gap(3'd6, 8'h40), "wrap_gap6");
    step(1'b0, 8'h61, 4'h0, v_sel(3'd0), "wrap_sel0");
    step(1'b0, 8'h61, 4'h0, v_gap(3'd0, 8'h01), "wrap_gap0");
    step(1'b0, 8'h61, 4'h0, v_sel(3'd5), "wrap_sel5");
    step(1'b0, 8'h61, 4'h0, v_gap(3'd5, 8'h20), "wrap_gap5");
    step(1'b0, 8'h00, 4'h0, v_idle(3'd5), "wrap_idle");

    // round robin 0/7 after reset
    step(1'b1, 8'h00, 4'h0, v_idle(3'd0), "rr_reset");
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 8'h81, 4'h0, v_sel(3'd0), "rr_sel0");
      step(1'b0, 8'h81, 4'h0, v_gap(3'd0, 8'h01), "rr_gap0");
      step(1'b0, 8'h81, 4'h0, v_sel(3'd7), "rr_sel7");
      step(1'b0, 8'h81, 4'h0, v_gap(3'd7, 8'h80), "rr_gap7");
    end
    step(1'b0, 8'h00, 4'h0, v_idle(3'd7), "rr_idle");

    // early release of requester 3 in its 2nd select cycle
    step(1'b0, 8'h08, 4'h7, v_sel(3'd3), "early_sel0");
    step(1'b0, 8'h08, 4'h7, v_sel(3'd3), "early_sel1");
    step(1'b0, 8'h00, 4'h7, v_gap(3'd3, 8'h00), "early_gap");
    step(1'b0, 8'h00, 4'h7, v_idle(3'd3), "early_idle0");
    step(1'b0, 8'h00, 4'h7, v_idle(3'd3), "early_idle1");

    // reset in the 3rd select cycle, then grant 2 after release
    step(1'b0, 8'h04, 4'h5, v_sel(3'd2), "rst_sel0");
    step(1'b0, 8'h04, 4'h5, v_sel(3'd2), "rst_sel1");
    step(1'b0, 8'h04, 4'h5, v_sel(3'd2), "rst_sel2");
    step(1'b1, 8'h04, 4'h5, v_idle(3'd0), "rst_mid");
    step(1'b0, 8'h04, 4'h0, v_sel(3'd2), "rst_regrant");
    step(1'b0, 8'h04, 4'h0, v_gap(3'd2, 8'h04), "rst_gap");
    step(1'b0, 8'h00, 4'h0, v_idle(3'd2), "rst_idle");

    // max dwell: 16 select cycles; ptr=3 so requester 1 wins
    for (int k = 0; k < 16; k++)
      step(1'b0, 8'h02, 4'hf, v_sel(3'd1), "maxdw_sel");
    step(1'b0, 8'h02, 4'h0, v_gap(3'd1, 8'h02), "maxdw_gap");
    step(1'b0, 8'h00, 4'h0, v_idle(3'd1), "maxdw_idle");

    @(negedge CLK);
    done = 1'b1;
  end

  initial begin : monitor
    logic [16:0] e;
    logic [16:0] got;
    string       nm;
    int          cyc;
    cyc = 0;
    while (!(done && exp_q.size() == 0) && cyc < 5000) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = {state_dbg, G1, G2A, G2B, C, B, A, ACK, BUSY};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, e);
        end
      end
    end
    if (exp_q.size() != 0 || !done) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d expected vectors left undrained", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
